// File: rtl/branch_ctrl.sv
// B/BL sequencer: condition check, target/link calc, redirect and flush.
// Optional per-outcome counters are built with BRANCH_CTRL_STATS_EN.
module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_offset,
    input  logic [31:0] req_pc,
    input  logic [3:0]  req_cond,
    input  logic        req_link,
    input  logic [3:0]  flags,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        lr_we,
    output logic [31:0] lr_data,
    output logic        flush,
    output logic        done,
    output logic        done_taken
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EVAL  = 3'd1;
    localparam logic [2:0] CALC  = 3'd2;
    localparam logic [2:0] LINK  = 3'd3;
    localparam logic [2:0] REDIR = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [23:0] offset_q, offset_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cond_q, cond_d;
    logic        link_q, link_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] target_q, target_d;
    logic [31:0] lr_q, lr_d;
    logic        nt_done_q, nt_done_d;
    logic        pass;
    logic        n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        pass = 1'b0;
        unique case (cond_q)
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            4'hE: pass = 1'b1;
            4'hF: pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        pc_d      = pc_q;
        cond_d    = cond_q;
        link_d    = link_q;
        flags_d   = flags_q;
        target_d  = target_q;
        lr_d      = lr_q;
        nt_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    offset_d = req_offset;
                    pc_d     = req_pc;
                    cond_d   = req_cond;
                    link_d   = req_link;
                    flags_d  = flags;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (pass) begin
                    state_d = CALC;
                end else begin
                    nt_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            CALC: begin
                // Word offset, sign-extended; pipeline PC is pc + 8.
                target_d = pc_q + 32'd8
                         + {{6{offset_q[23]}}, offset_q, 2'b00};
                lr_d     = pc_q + 32'd4;
                state_d  = LINK;
            end
            LINK:    state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            pc_q      <= '0;
            cond_q    <= '0;
            link_q    <= 1'b0;
            flags_q   <= '0;
            target_q  <= '0;
            lr_q      <= '0;
            nt_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            pc_q      <= pc_d;
            cond_q    <= cond_d;
            link_q    <= link_d;
            flags_q   <= flags_d;
            target_q  <= target_d;
            lr_q      <= lr_d;
            nt_done_q <= nt_done_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign lr_we      = (state_q == LINK) && link_q;
    assign pc_load    = (state_q == REDIR);
    assign flush      = (state_q == REDIR);
    assign done_taken = (state_q == REDIR);
    assign done       = (state_q == REDIR) || nt_done_q;
    assign pc_target  = target_q;
    assign lr_data    = lr_q;

`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] nottaken_cnt_q, nottaken_cnt_d;

    // Counters saturate rather than wrap.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (state_q == REDIR && taken_cnt_q != 16'hFFFF)
            taken_cnt_d = taken_cnt_q + 16'd1;
        if (nt_done_q && nottaken_cnt_q != 16'hFFFF)
            nottaken_cnt_d = nottaken_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed table-driven bench for branch_ctrl plus reset/back-to-back sequences.
module tb_branch_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_offset;
    logic [31:0] req_pc;
    logic [3:0]  req_cond;
    logic        req_link;
    logic [3:0]  flags;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        flush;
    logic        done;
    logic        done_taken;
`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
`endif

    branch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_offset (req_offset),
        .req_pc     (req_pc),
        .req_cond   (req_cond),
        .req_link   (req_link),
        .flags      (flags),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .lr_we      (lr_we),
        .lr_data    (lr_data),
        .flush      (flush),
        .done       (done),
        .done_taken (done_taken)
`ifdef BRANCH_CTRL_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] offset;
        logic [31:0] pc;
        logic [3:0]  cond;
        logic        link;
        logic [3:0]  flg;
        logic        taken;
        logic [31:0] target;
        logic [31:0] lr;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_chk;
    int n_fail;
    logic [31:0] prev_target;
    logic [31:0] prev_lr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prev_target = '0;
        prev_lr     = '0;
    endtask

    task automatic run_vec(input int i);
        logic [5:0]  m_ld, m_fl, m_we, m_dn, m_dt, m_rdy;
        logic [31:0] tgt4, lr3;
        logic [5:0]  e_tk;
        vec_t t;
        t = vecs[i];
        m_ld = '0; m_fl = '0; m_we = '0;
        m_dn = '0; m_dt = '0; m_rdy = '0;
        tgt4 = '0; lr3 = '0;
        @(negedge clk);
        req_offset = t.offset;
        req_pc     = t.pc;
        req_cond   = t.cond;
        req_link   = t.link;
        flags      = t.flg;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        // scramble everything after accept; the block must not notice
        req_valid  = 1'b0;
        req_offset = 24'($urandom);
        req_pc     = $urandom;
        req_cond   = 4'($urandom);
        req_link   = ~t.link;
        flags      = ~t.flg;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            m_ld[c-1]  = pc_load;
            m_fl[c-1]  = flush;
            m_we[c-1]  = lr_we;
            m_dn[c-1]  = done;
            m_dt[c-1]  = done_taken;
            m_rdy[c-1] = req_ready;
            if (c == 4) tgt4 = pc_target;
            if (c == 3) lr3 = lr_data;
        end
        e_tk = t.taken ? 6'b001000 : 6'b000000;
        chk($sformatf("v%0d pc_load", i), 32'(m_ld), 32'(e_tk));
        chk($sformatf("v%0d flush", i), 32'(m_fl), 32'(e_tk));
        chk($sformatf("v%0d done_taken", i), 32'(m_dt), 32'(e_tk));
        chk($sformatf("v%0d done", i), 32'(m_dn),
            t.taken ? 32'h08 : 32'h02);
        chk($sformatf("v%0d lr_we", i), 32'(m_we),
            (t.taken && t.link) ? 32'h04 : 32'h00);
        chk($sformatf("v%0d req_ready", i), 32'(m_rdy),
            t.taken ? 32'h30 : 32'h3E);
        if (t.taken) begin
            prev_target = t.target;
            prev_lr     = t.lr;
        end
        chk($sformatf("v%0d pc_target", i), tgt4, prev_target);
        chk($sformatf("v%0d lr_data", i), lr3, prev_lr);
    endtask

    initial begin
        logic [3:0] m4_rdy, m4_dn;
        int pulses;
        n_chk = 0;
        n_fail = 0;
        prev_target = '0;
        prev_lr = '0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_offset = '0;
        req_pc = '0;
        req_cond = '0;
        req_link = 1'b0;
        flags = '0;

        //        offset      pc             cond  lk  flags  tk  target         lr
        vecs[0]  = '{24'h000010, 32'h0000_0100, 4'hE, 1'b1, 4'h0, 1'b1, 32'h0000_0148, 32'h0000_0104};
        vecs[1]  = '{24'hD55555, 32'h0000_1000, 4'hE, 1'b0, 4'h0, 1'b1, 32'hFF55_655C, 32'h0000_1004};
        vecs[2]  = '{24'h000000, 32'h0000_0500, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{24'h000001, 32'hFFFF_FFF8, 4'hE, 1'b0, 4'h0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFC};
        vecs[4]  = '{24'h000000, 32'h0000_0200, 4'h1, 1'b1, 4'h0, 1'b1, 32'h0000_0208, 32'h0000_0204};
        vecs[5]  = '{24'hFFFFFF, 32'h0000_0000, 4'h8, 1'b0, 4'h2, 1'b1, 32'h0000_0004, 32'h0000_0004};
        vecs[6]  = '{24'h000000, 32'h0000_0000, 4'h9, 1'b1, 4'h2, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{24'h000002, 32'h0000_0040, 4'hA, 1'b1, 4'h9, 1'b1, 32'h0000_0050, 32'h0000_0044};
        vecs[8]  = '{24'h000000, 32'h0000_0000, 4'hB, 1'b1, 4'h9, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{24'h000000, 32'h0000_0000, 4'hC, 1'b1, 4'h4, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{24'h000000, 32'h0000_0080, 4'hD, 1'b0, 4'h4, 1'b1, 32'h0000_0088, 32'h0000_0084};
        vecs[11] = '{24'h000000, 32'h0000_0000, 4'hF, 1'b1, 4'hF, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{24'h000000, 32'h0000_0000, 4'h4, 1'b1, 4'h8, 1'b1, 32'h0000_0008, 32'h0000_0004};
        vecs[13] = '{24'h000000, 32'h0000_0000, 4'h7, 1'b1, 4'h1, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{24'h000003, 32'h0000_0010, 4'h2, 1'b0, 4'h2, 1'b1, 32'h0000_0024, 32'h0000_0014};

        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'h1);
        chk("rst pulses", {27'd0, pc_load, flush, lr_we, done, done_taken}, 32'h0);
        chk("rst pc_target", pc_target, 32'h0);
        chk("rst lr_data", lr_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // back-to-back not-taken: second accept at E2
        @(negedge clk);
        req_offset = '0;
        req_pc = 32'h700;
        req_cond = 4'h0;
        req_link = 1'b0;
        flags = 4'h0;
        req_valid = 1'b1;
        m4_rdy = '0;
        m4_dn = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) req_valid = 1'b0;
            m4_rdy[c-1] = req_ready;
            m4_dn[c-1]  = done;
        end
        chk("b2b req_ready", 32'(m4_rdy), 32'hA);
        chk("b2b done", 32'(m4_dn), 32'hA);
        chk("b2b pc_load", 32'(pc_load), 32'h0);
        repeat (2) @(posedge clk);

`ifdef BRANCH_CTRL_STATS_EN
        do_reset();
        chk("stats rst taken", 32'(taken_cnt), 32'h0);
        run_vec(0);
        run_vec(2);
        run_vec(3);
        run_vec(6);
        run_vec(4);
        chk("stats taken", 32'(taken_cnt), 32'd3);
        chk("stats nottaken", 32'(nottaken_cnt), 32'd2);
        @(negedge clk);
        force dut.taken_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.taken_cnt_q;
        run_vec(0);
        chk("stats sat", 32'(taken_cnt), 32'hFFFF);
        chk("stats nottaken hold", 32'(nottaken_cnt), 32'd2);
`endif

        // reset during LINK of a BL
        @(negedge clk);
        req_offset = 24'h4;
        req_pc = 32'h300;
        req_cond = 4'hE;
        req_link = 1'b1;
        flags = 4'h0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("abort in LINK lr_we", 32'(lr_we), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'h1);
        chk("abort pulses", {27'd0, pc_load, flush, lr_we, done, done_taken}, 32'h0);
        chk("abort pc_target", pc_target, 32'h0);
        chk("abort lr_data", lr_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(pc_load) + int'(flush) + int'(done) + int'(lr_we);
        end
        chk("abort no pulses", 32'(pulses), 32'h0);
        chk("abort ready after", 32'(req_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
